// File: rtl/ps2_decoder.sv
// PS/2 keyboard receiver: synchronizes and deglitches ps2Ck/ps2D, frames 11-bit words, strips E0/F0 prefixes.
// Optional stall watchdog is enabled by defining PS2_DECODER_TIMEOUT_EN.
module ps2_decoder #(
  parameter int FILTER  = 8,
  parameter int TIMEOUT = 20000
) (
  input  logic       clock,
  input  logic       reset,
  input  logic       ps2Ck,
  input  logic       ps2D,
  output logic [7:0] code,
  output logic       strobe,
  output logic       pressed,
  output logic       extended,
  output logic       error
);

  localparam int FW = $clog2(FILTER + 1);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    DATA   = 2'd1,
    PARITY = 2'd2,
    STOP   = 2'd3
  } state_t;

  // Odd parity holds when the ones-count over data plus parity bit is odd.
  function automatic logic oddOnes(input logic [8:0] v);
    return ^v;
  endfunction

  logic [1:0]    ckSync_r, dSync_r;
  logic [FW-1:0] ckCnt_r, dCnt_r;
  logic          ckFilt_r, dFilt_r, ckPrev_r;
  logic          fallEdge_s;

  state_t        state_r, stateNext_s;
  logic [2:0]    bitCnt_r, bitCntNext_s;
  logic [7:0]    shift_r, shiftNext_s;
  logic          parity_r, parityNext_s;
  logic          extFlag_r, extFlagNext_s, brkFlag_r, brkFlagNext_s;
  logic [7:0]    codeNext_s;
  logic          pressedNext_s, extendedNext_s, strobeNext_s, errorNext_s;
  logic          wdExpire_s;

  // Input synchronizers and glitch filters; idle bus level is high.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      ckSync_r <= 2'b11;
      dSync_r  <= 2'b11;
      ckCnt_r  <= FW'(0);
      dCnt_r   <= FW'(0);
      ckFilt_r <= 1'b1;
      dFilt_r  <= 1'b1;
      ckPrev_r <= 1'b1;
    end else begin
      ckSync_r <= {ckSync_r[0], ps2Ck};
      dSync_r  <= {dSync_r[0], ps2D};
      ckPrev_r <= ckFilt_r;
      if (ckSync_r[1] == ckFilt_r) begin
        ckCnt_r <= FW'(0);
      end else if (ckCnt_r == FW'(FILTER - 1)) begin
        ckFilt_r <= ckSync_r[1];
        ckCnt_r  <= FW'(0);
      end else begin
        ckCnt_r <= ckCnt_r + FW'(1);
      end
      if (dSync_r[1] == dFilt_r) begin
        dCnt_r <= FW'(0);
      end else if (dCnt_r == FW'(FILTER - 1)) begin
        dFilt_r <= dSync_r[1];
        dCnt_r  <= FW'(0);
      end else begin
        dCnt_r <= dCnt_r + FW'(1);
      end
    end
  end

  assign fallEdge_s = ckPrev_r & ~ckFilt_r;

`ifdef PS2_DECODER_TIMEOUT_EN
  localparam int WW = $clog2(TIMEOUT + 1);
  logic [WW-1:0] wdCnt_r;

  // Watchdog counts cycles since the last sample edge while a frame is open.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      wdCnt_r <= WW'(0);
    end else if ((state_r == IDLE) || fallEdge_s || wdExpire_s) begin
      wdCnt_r <= WW'(0);
    end else begin
      wdCnt_r <= wdCnt_r + WW'(1);
    end
  end

  assign wdExpire_s = (state_r != IDLE) && !fallEdge_s && (wdCnt_r == WW'(TIMEOUT - 1));
`else
  // TIMEOUT only matters when the watchdog is built in.
  if (TIMEOUT < 1) begin : gTimeoutRange
  end
  assign wdExpire_s = 1'b0;
`endif

  // Frame sequencer, prefix tracking and next output values.
  always_comb begin
    stateNext_s    = state_r;
    bitCntNext_s   = bitCnt_r;
    shiftNext_s    = shift_r;
    parityNext_s   = parity_r;
    extFlagNext_s  = extFlag_r;
    brkFlagNext_s  = brkFlag_r;
    codeNext_s     = code;
    pressedNext_s  = pressed;
    extendedNext_s = extended;
    strobeNext_s   = 1'b0;
    errorNext_s    = 1'b0;
    if (wdExpire_s) begin
      stateNext_s   = IDLE;
      extFlagNext_s = 1'b0;
      brkFlagNext_s = 1'b0;
      errorNext_s   = 1'b1;
    end else begin
      case (state_r)
        IDLE: begin
          if (fallEdge_s && !dFilt_r) begin
            stateNext_s  = DATA;
            bitCntNext_s = 3'd0;
          end else begin
            stateNext_s = IDLE;
          end
        end
        DATA: begin
          if (fallEdge_s) begin
            shiftNext_s = {dFilt_r, shift_r[7:1]};
            if (bitCnt_r == 3'd7) begin
              stateNext_s = PARITY;
            end else begin
              bitCntNext_s = bitCnt_r + 3'd1;
            end
          end else begin
            stateNext_s = DATA;
          end
        end
        PARITY: begin
          if (fallEdge_s) begin
            parityNext_s = dFilt_r;
            stateNext_s  = STOP;
          end else begin
            stateNext_s = PARITY;
          end
        end
        STOP: begin
          if (fallEdge_s) begin
            stateNext_s = IDLE;
            if (dFilt_r && oddOnes({parity_r, shift_r})) begin
              if (shift_r == 8'hE0) begin
                extFlagNext_s = 1'b1;
              end else if (shift_r == 8'hF0) begin
                brkFlagNext_s = 1'b1;
              end else begin
                codeNext_s     = shift_r;
                pressedNext_s  = !brkFlag_r;
                extendedNext_s = extFlag_r;
                strobeNext_s   = 1'b1;
                extFlagNext_s  = 1'b0;
                brkFlagNext_s  = 1'b0;
              end
            end else begin
              errorNext_s   = 1'b1;
              extFlagNext_s = 1'b0;
              brkFlagNext_s = 1'b0;
            end
          end else begin
            stateNext_s = STOP;
          end
        end
        default: begin
          stateNext_s = IDLE;
        end
      endcase
    end
  end

  // Sequencer state and registered outputs.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state_r   <= IDLE;
      bitCnt_r  <= 3'd0;
      shift_r   <= 8'h00;
      parity_r  <= 1'b0;
      extFlag_r <= 1'b0;
      brkFlag_r <= 1'b0;
      code      <= 8'h00;
      pressed   <= 1'b0;
      extended  <= 1'b0;
      strobe    <= 1'b0;
      error     <= 1'b0;
    end else begin
      state_r   <= stateNext_s;
      bitCnt_r  <= bitCntNext_s;
      shift_r   <= shiftNext_s;
      parity_r  <= parityNext_s;
      extFlag_r <= extFlagNext_s;
      brkFlag_r <= brkFlagNext_s;
      code      <= codeNext_s;
      pressed   <= pressedNext_s;
      extended  <= extendedNext_s;
      strobe    <= strobeNext_s;
      error     <= errorNext_s;
    end
  end

endmodule

// File: tb/tb_ps2_decoder.sv
// Scoreboard bench for ps2_decoder: random and directed PS/2 frames against a byte-level reference model.
module tb_ps2_decoder;
  localparam int FILTER  = 8;
  localparam int TIMEOUT = 3000;
  localparam int HALF    = 20;

  logic       clock = 1'b0;
  logic       reset = 1'b0;
  logic       ps2Ck = 1'b1;
  logic       ps2D  = 1'b1;
  logic [7:0] code;
  logic       strobe, pressed, extended, error;

  ps2_decoder #(.FILTER(FILTER), .TIMEOUT(TIMEOUT)) dut (
    .clock(clock), .reset(reset), .ps2Ck(ps2Ck), .ps2D(ps2D),
    .code(code), .strobe(strobe), .pressed(pressed), .extended(extended), .error(error)
  );

  always #5 clock = ~clock;

  typedef struct {
    bit         isErr;
    logic [7:0] code;
    bit         pressed;
    bit         extended;
  } exp_t;

  exp_t       expQ[$];
  int         compared   = 0;
  int         mismatched = 0;
  bit         mExt = 1'b0, mBrk = 1'b0;
  logic [7:0] lastCode = 8'h00;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    compared++;
    if (act !== req) begin
      mismatched++;
      $display("FAIL %s actual=%0h required=%0h at %0t", name, act, req, $time);
    end
  endtask

  // Reference model: what a keyboard byte means once framing is correct or broken.
  task automatic modelFrame(input logic [7:0] b, input bit bad);
    exp_t e;
    if (bad) begin
      e = '{isErr: 1'b1, code: 8'h00, pressed: 1'b0, extended: 1'b0};
      expQ.push_back(e);
      mExt = 1'b0; mBrk = 1'b0;
    end else if (b == 8'hE0) begin
      mExt = 1'b1;
    end else if (b == 8'hF0) begin
      mBrk = 1'b1;
    end else begin
      e = '{isErr: 1'b0, code: b, pressed: !mBrk, extended: mExt};
      expQ.push_back(e);
      mExt = 1'b0; mBrk = 1'b0;
    end
  endtask

  // Monitor: every strobe or error pulse is matched against the scoreboard.
  always @(negedge clock) begin
    exp_t e;
    if (reset && (strobe || error)) begin
      if (expQ.size() == 0) begin
        check("unexpectedPulse", {30'd0, strobe, error}, 32'd0);
      end else begin
        e = expQ.pop_front();
        check("pulseIsError", 32'(error), 32'(e.isErr));
        check("pulseIsStrobe", 32'(strobe), 32'(!e.isErr));
        if (!e.isErr) begin
          check("code", 32'(code), 32'(e.code));
          check("pressed", 32'(pressed), 32'(e.pressed));
          check("extended", 32'(extended), 32'(e.extended));
          lastCode = e.code;
        end else begin
          check("codeHeldOnError", 32'(code), 32'(lastCode));
        end
      end
    end
  end

  task automatic waitCyc(input int n);
    repeat (n) @(posedge clock);
    #1;
  endtask

  task automatic sendBit(input bit v, input bit glitch);
    ps2D = v;
    if (glitch) begin
      waitCyc(6);
      ps2Ck = 1'b0;
      waitCyc(FILTER - 1);
      ps2Ck = 1'b1;
      waitCyc(HALF - 6 - (FILTER - 1) + 8);
    end else begin
      waitCyc(HALF);
    end
    ps2Ck = 1'b0;
    waitCyc(HALF);
    ps2Ck = 1'b1;
  endtask

  task automatic sendBits(input logic [7:0] b, input bit bad, input int nBits, input bit glitchy);
    logic [10:0] w;
    w = {1'b1, (~^b) ^ bad, b, 1'b0};
    for (int i = 0; i < nBits; i++) begin
      sendBit(w[i], glitchy && ($urandom_range(0, 2) == 0));
    end
  endtask

  task automatic sendFrame(input logic [7:0] b, input bit bad, input bit glitchy);
    modelFrame(b, bad);
    sendBits(b, bad, 11, glitchy);
    ps2D = 1'b1;
    waitCyc(HALF);
  endtask

  initial begin
    logic [7:0] b;
    int         r;
    waitCyc(10);
    check("resetCode", 32'(code), 32'h00);
    check("resetStrobe", 32'(strobe), 32'd0);
    check("resetPressed", 32'(pressed), 32'd0);
    check("resetExtended", 32'(extended), 32'd0);
    check("resetError", 32'(error), 32'd0);
    reset = 1'b1;
    waitCyc(10);

    // Short low glitch while idle must not look like a start bit.
    ps2Ck = 1'b0; ps2D = 1'b0;
    waitCyc(FILTER - 1);
    ps2Ck = 1'b1; ps2D = 1'b1;
    waitCyc(40);

    sendFrame(8'h1C, 1'b0, 1'b0);
    sendFrame(8'hF0, 1'b0, 1'b0); sendFrame(8'h1C, 1'b0, 1'b0);
    sendFrame(8'hE0, 1'b0, 1'b0); sendFrame(8'hF0, 1'b0, 1'b0); sendFrame(8'h75, 1'b0, 1'b0);
    sendFrame(8'h75, 1'b0, 1'b0);
    sendFrame(8'h1C, 1'b1, 1'b0); sendFrame(8'h1C, 1'b0, 1'b0);
    sendFrame(8'hF0, 1'b0, 1'b0); sendFrame(8'hE0, 1'b0, 1'b0); sendFrame(8'h75, 1'b0, 1'b0);
    sendFrame(8'hE0, 1'b0, 1'b0); sendFrame(8'hE0, 1'b0, 1'b0); sendFrame(8'h1C, 1'b0, 1'b0);
    sendFrame(8'hE1, 1'b0, 1'b0);
    sendFrame(8'h1C, 1'b0, 1'b1);

    for (int n = 0; n < 45; n++) begin
      r = $urandom_range(0, 99);
      if (r < 25) b = 8'hE0;
      else if (r < 40) b = 8'hF0;
      else b = 8'($urandom_range(0, 255));
      sendFrame(b, ($urandom_range(0, 9) == 0), ($urandom_range(0, 3) == 0));
    end

    // Reset in the middle of a frame discards it silently.
    sendBits(8'h1C, 1'b0, 6, 1'b0);
    reset = 1'b0;
    waitCyc(5);
    check("midResetCode", 32'(code), 32'h00);
    check("midResetPressed", 32'(pressed), 32'd0);
    ps2Ck = 1'b1; ps2D = 1'b1;
    mExt = 1'b0; mBrk = 1'b0; lastCode = 8'h00;
    waitCyc(5);
    reset = 1'b1;
    waitCyc(20);
    sendFrame(8'h1C, 1'b0, 1'b0);

`ifdef PS2_DECODER_TIMEOUT_EN
    sendFrame(8'hE0, 1'b0, 1'b0);
    sendBits(8'h1C, 1'b0, 5, 1'b0);
    modelFrame(8'h00, 1'b1);
    ps2D = 1'b1;
    waitCyc(TIMEOUT + 200);
    check("timeoutErrorSeen", 32'(expQ.size()), 32'd0);
    sendFrame(8'h1C, 1'b0, 1'b0);
`endif

    waitCyc(200);
    check("scoreboardDrained", 32'(expQ.size()), 32'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end
endmodule
